// File: rtl/hazard_scoreboard.sv
// Per-register write scoreboard beside decode.
// Drives the decode stall from outstanding producer countdowns.
module hazard_scoreboard #(
  parameter int CNT_W      = 3,
  parameter int LOAD_STALL = 1,
  parameter int ALU_STALL  = 0,
  parameter int SCNT_W     = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dec_valid,
  input  logic [4:0]        rs1_sel,
  input  logic [4:0]        rs2_sel,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [4:0]        dec_rd,
  input  logic              dec_is_wb,
  input  logic              dec_is_load,
  input  logic              dcache_stall,
  input  logic              wb_en,
  input  logic [4:0]        wb_sel,
  output logic              stall,
  output logic              issue,
  output logic [31:0]       pending_mask,
  output logic [SCNT_W-1:0] stall_count
);

  localparam logic [CNT_W-1:0] LD_INIT = CNT_W'(LOAD_STALL);
  localparam logic [CNT_W-1:0] AL_INIT = CNT_W'(ALU_STALL);

  logic [31:0]      pend;
  logic [CNT_W-1:0] tmr [32];
  logic             hz1;
  logic             hz2;
  logic             set_en;
  logic             clr_en;

  assign hz1 = rs1_used && (rs1_sel != 5'd0)
            && pend[rs1_sel] && (tmr[rs1_sel] != '0);
  assign hz2 = rs2_used && (rs2_sel != 5'd0)
            && pend[rs2_sel] && (tmr[rs2_sel] != '0);

  assign stall  = dec_valid && (hz1 || hz2);
  assign issue  = dec_valid && !stall && !dcache_stall;
  assign set_en = issue && dec_is_wb && (dec_rd != 5'd0);
  assign clr_en = wb_en && (wb_sel != 5'd0);

  assign pending_mask = pend;

  // Entry 0 is never written, so it reads back as idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend <= '0;
      for (int i = 0; i < 32; i++) begin
        tmr[i] <= '0;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (set_en && (dec_rd == 5'(r))) begin
          pend[r] <= 1'b1;
          tmr[r]  <= dec_is_load ? LD_INIT : AL_INIT;
        end else if (clr_en && (wb_sel == 5'(r))) begin
          pend[r] <= 1'b0;
          tmr[r]  <= '0;
        end else if (!dcache_stall && (tmr[r] != '0)) begin
          tmr[r] <= tmr[r] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (stall && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: directed scenarios plus
// randomized traffic against a per-register reference model.
module tb_hazard_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dec_valid;
  logic [4:0]  rs1_sel;
  logic [4:0]  rs2_sel;
  logic        rs1_used;
  logic        rs2_used;
  logic [4:0]  dec_rd;
  logic        dec_is_wb;
  logic        dec_is_load;
  logic        dcache_stall;
  logic        wb_en;
  logic [4:0]  wb_sel;
  logic        stall;
  logic        issue;
  logic [31:0] pending_mask;
  logic [3:0]  stall_count;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bit m_pend [32];
  int m_tmr  [32];
  int m_cnt;

  hazard_scoreboard #(
    .CNT_W(3), .LOAD_STALL(1), .ALU_STALL(0), .SCNT_W(4)
  ) dut (
    .clock(clock), .reset(reset),
    .dec_valid(dec_valid),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel),
    .rs1_used(rs1_used), .rs2_used(rs2_used),
    .dec_rd(dec_rd), .dec_is_wb(dec_is_wb),
    .dec_is_load(dec_is_load),
    .dcache_stall(dcache_stall),
    .wb_en(wb_en), .wb_sel(wb_sel),
    .stall(stall), .issue(issue),
    .pending_mask(pending_mask),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic bit m_hz(logic [4:0] s, logic u);
    return u && s != 0 && m_pend[s] && m_tmr[s] != 0;
  endfunction

  function automatic bit m_stall();
    return dec_valid &&
      (m_hz(rs1_sel, rs1_used) || m_hz(rs2_sel, rs2_used));
  endfunction

  function automatic logic [31:0] m_mask();
    logic [31:0] m;
    m = '0;
    for (int r = 1; r < 32; r++) m[r] = m_pend[r];
    return m;
  endfunction

  // Reference model: rules applied directly to plain arrays.
  always @(posedge clock or posedge reset) begin
    bit s;
    bit i;
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_pend[r] = 0;
        m_tmr[r]  = 0;
      end
      m_cnt = 0;
    end else begin
      s = m_stall();
      i = dec_valid && !s && !dcache_stall;
      if (s && m_cnt < 15) m_cnt++;
      for (int r = 1; r < 32; r++)
        if (!dcache_stall && m_tmr[r] > 0) m_tmr[r]--;
      if (wb_en && wb_sel != 0) begin
        m_pend[wb_sel] = 0;
        m_tmr[wb_sel]  = 0;
      end
      if (i && dec_is_wb && dec_rd != 0) begin
        m_pend[dec_rd] = 1;
        m_tmr[dec_rd]  = dec_is_load ? 1 : 0;
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en && !reset) begin
      chk("m_stall", {31'd0, stall}, {31'd0, m_stall()});
      chk("m_issue", {31'd0, issue},
          {31'd0, dec_valid && !m_stall() && !dcache_stall});
      chk("m_mask", pending_mask, m_mask());
      chk("m_cnt", {28'd0, stall_count}, m_cnt);
    end
  end

  task automatic drv(logic v, logic [4:0] r1, logic u1,
                     logic [4:0] r2, logic u2,
                     logic [4:0] rd, logic wb, logic ld,
                     logic dc, logic we, logic [4:0] ws);
    dec_valid = v;   rs1_sel = r1; rs1_used = u1;
    rs2_sel = r2;    rs2_used = u2;
    dec_rd = rd;     dec_is_wb = wb; dec_is_load = ld;
    dcache_stall = dc;
    wb_en = we;      wb_sel = ws;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic nxt();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    nxt();
    reset = 1'b0;
  endtask

  initial begin
    idle();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mask", pending_mask, 0);
    chk("rst_stall", {31'd0, stall}, 0);
    chk("rst_cnt", {28'd0, stall_count}, 0);
    dec_valid = 1'b1;
    #1;
    chk("rst_issue", {31'd0, issue}, 1);
    idle();
    reset = 1'b0;
    chk_en = 1'b1;
    nxt();

    // load-use
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    @(negedge clock);
    chk("lu_issue0", {31'd0, issue}, 1);
    nxt();
    drv(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("lu_stall1", {31'd0, stall}, 1);
    chk("lu_issue1", {31'd0, issue}, 0);
    chk("lu_mask1", pending_mask, 32'h20);
    nxt();
    @(negedge clock);
    chk("lu_stall2", {31'd0, stall}, 0);
    chk("lu_issue2", {31'd0, issue}, 1);
    chk("lu_cnt2", {28'd0, stall_count}, 1);
    nxt();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5);
    chk("lu_mask3", pending_mask, 32'h60);
    nxt();
    chk("lu_wb_mask", pending_mask, 32'h40);

    // ALU back-to-back
    do_reset();
    drv(1, 0, 1, 0, 0, 1, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("alu_stall0", {31'd0, stall}, 0);
    nxt();
    drv(1, 1, 1, 1, 1, 2, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("alu_stall1", {31'd0, stall}, 0);
    chk("alu_issue1", {31'd0, issue}, 1);
    nxt();
    idle();
    chk("alu_mask", pending_mask, 32'h6);

    // dcache freeze holds the load timer
    do_reset();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    nxt();
    drv(1, 0, 0, 7, 1, 8, 1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("dc_stall", {31'd0, stall}, 1);
      chk("dc_issue", {31'd0, issue}, 0);
      nxt();
    end
    dcache_stall = 1'b0;
    @(negedge clock);
    chk("dc_tail_stall", {31'd0, stall}, 1);
    nxt();
    @(negedge clock);
    chk("dc_done_stall", {31'd0, stall}, 0);
    chk("dc_done_issue", {31'd0, issue}, 1);
    chk("dc_cnt", {28'd0, stall_count}, 4);
    nxt();
    idle();

    // issue and writeback collide on x9
    do_reset();
    drv(1, 0, 0, 0, 0, 9, 1, 1, 0, 1, 9);
    nxt();
    chk("col_mask", pending_mask, 32'h200);
    drv(1, 9, 1, 0, 0, 10, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("col_stall", {31'd0, stall}, 1);
    nxt();
    do_reset();
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0);
    nxt();
    chk("x0_mask", pending_mask, 0);

    // asynchronous reset mid-stall
    do_reset();
    drv(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    nxt();
    drv(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0);
    nxt();
    drv(1, 7, 1, 0, 0, 1, 1, 0, 1, 0, 0);
    nxt();
    @(negedge clock);
    chk("ar_mask_pre", pending_mask, 32'hA0);
    chk("ar_stall_pre", {31'd0, stall}, 1);
    chk("ar_cnt_pre", {28'd0, stall_count}, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_mask", pending_mask, 0);
    chk("ar_stall", {31'd0, stall}, 0);
    chk("ar_cnt", {28'd0, stall_count}, 0);
    #1 reset = 1'b0;
    nxt();
    idle();

    // counter saturation
    do_reset();
    drv(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0);
    nxt();
    drv(1, 3, 1, 0, 0, 4, 1, 0, 1, 0, 0);
    repeat (20) nxt();
    @(negedge clock);
    chk("sat_cnt", {28'd0, stall_count}, 15);
    chk("sat_stall", {31'd0, stall}, 1);
    nxt();

    // randomized traffic
    for (int ep = 0; ep < 6; ep++) begin
      do_reset();
      for (int c = 0; c < 300; c++) begin
        drv($urandom_range(0, 4) != 0,
            5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)), 1'($urandom),
            5'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0, 1'($urandom),
            $urandom_range(0, 5) == 0,
            $urandom_range(0, 2) == 0,
            5'($urandom_range(0, 7)));
        nxt();
      end
    end

    idle();
    nxt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
